// File: rtl/async_sender.sv
// async_sender: bundled-data 4-phase sender.
// A word accepted on the valid/ready interface is placed on BusData. One cycle later rqst
// is raised. The block then waits for the synchronized ack to rise, drops rqst, and waits
// for ack to fall before it reports completion with a one-cycle sent pulse.
//
// Build option: define ASYNC_SENDER_FIFO_EN to replace the single holding register with
// a 4-entry FIFO. Without the macro, one holding register buffers a single word.

module async_sender #(
  parameter int unsigned B = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [B-1:0] din,
  output logic         ready,
  input  logic         ack,
  output logic         rqst,
  output logic [B-1:0] BusData,
  output logic         sent
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    RQST    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;

  // ack comes from another timing domain; only acksync is used past this point.
  logic ack_meta;
  logic acksync;

  // Storage interface shared by both build variants.
  logic         push;    // word accepted this cycle
  logic         pop;     // FSM takes the oldest stored word this cycle
  logic         stored;  // at least one word waiting
  logic [B-1:0] head;    // oldest stored word

  assign push = valid && ready;
  // A new handshake starts only from IDLE, only with a word on hand, and only once the
  // receiver has dropped ack from the previous handshake.
  assign pop  = (state == IDLE) && stored && !acksync;

  // Two-flop synchronizer for the receiver acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta <= 1'b0;
      acksync  <= 1'b0;
    end else begin
      ack_meta <= ack;
      acksync  <= ack_meta;
    end
  end

`ifdef ASYNC_SENDER_FIFO_EN

  logic [B-1:0] mem [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic [2:0]   count;

  assign ready  = (count != 3'd4);
  assign stored = (count != 3'd0);
  assign head   = mem[rd_ptr];

  // FIFO pointers and occupancy; a push and pop in the same cycle leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage array; cleared on reset so head never reads unknown data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= din;
    end
  end

`else

  logic [B-1:0] hold_q;
  logic         full_q;

  assign ready  = !full_q;
  assign stored = full_q;
  assign head   = hold_q;

  // Single holding register; push only when empty and pop only when full, so they never
  // coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (push) begin
      hold_q <= din;
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

`endif

  // Handshake FSM with registered rqst, BusData and sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rqst    <= 1'b0;
      BusData <= '0;
      sent    <= 1'b0;
    end else begin
      sent <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            BusData <= head;
            state   <= SETUP;
          end
        end
        // One full cycle of data setup before rqst rises.
        SETUP: begin
          rqst  <= 1'b1;
          state <= RQST;
        end
        RQST: begin
          if (acksync) begin
            rqst  <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!acksync) begin
            sent  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          rqst  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
